// File: rtl/issue_sequencer.sv
// ---------------------------------------------------------------------------
// issue_sequencer
//   Single reader of the DRAM issue FIFO. Each cycle it inspects the FIFO head,
//   checks bank state and DRAM timing, pops the head when it may go, and drives
//   the popped command onto the PHY command port one cycle later.
//
//   Ports
//     clk, rst_n              clock, synchronous active-low reset
//     fifo_empty/cmd/addr/bank  FIFO head entry
//     fifo_ren                pop strobe (combinational)
//     phy_ready               PHY accepts a command this cycle
//     dram_valid/cmd/addr/bank  registered command, valid for one cycle
//     bank_open               per-bank open flags
//     cmd_err                 one-cycle pulse: a state-illegal head was dropped
//     busy                    FSM not idle
//
//   Timing counters load T_X-1 on the pop edge and count down to 0, so a
//   counter reads 0 exactly T_X cycles after the constraining pop.
// ---------------------------------------------------------------------------

// Per-bank open flag plus tRCD / tRP / tRAS down-counters.
module issue_seq_bank_timer #(
   parameter int T_RCD = 4,
   parameter int T_RP  = 4,
   parameter int T_RAS = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic act_i,     // ACT issued to this bank this cycle
   input  logic pre_i,     // PRE issued to this bank this cycle
   output logic open_o,
   output logic rcd_ok_o,
   output logic rp_ok_o,
   output logic ras_ok_o
);
   localparam logic [4:0] RCD_LD = 5'(T_RCD - 1);
   localparam logic [4:0] RP_LD  = 5'(T_RP - 1);
   localparam logic [4:0] RAS_LD = 5'(T_RAS - 1);

   logic       open_q, open_d;
   logic [4:0] rcd_q, rcd_d, rp_q, rp_d, ras_q, ras_d;

   function automatic logic [4:0] dec5(input logic [4:0] v);
      return (v == 5'd0) ? 5'd0 : v - 5'd1;
   endfunction

   always_comb begin
      open_d = open_q;
      rcd_d  = dec5(rcd_q);
      rp_d   = dec5(rp_q);
      ras_d  = dec5(ras_q);
      if (act_i) begin
         open_d = 1'b1;
         rcd_d  = RCD_LD;
         ras_d  = RAS_LD;
      end
      if (pre_i) begin
         open_d = 1'b0;
         rp_d   = RP_LD;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         open_q <= 1'b0;
         rcd_q  <= 5'd0;
         rp_q   <= 5'd0;
         ras_q  <= 5'd0;
      end else begin
         open_q <= open_d;
         rcd_q  <= rcd_d;
         rp_q   <= rp_d;
         ras_q  <= ras_d;
      end
   end

   assign open_o   = open_q;
   assign rcd_ok_o = (rcd_q == 5'd0);
   assign rp_ok_o  = (rp_q == 5'd0);
   assign ras_ok_o = (ras_q == 5'd0);
endmodule

module issue_sequencer #(
   parameter int BA_BITS   = 3,
   parameter int ADDR_BITS = 14,
   parameter int T_RCD     = 4,
   parameter int T_RP      = 4,
   parameter int T_RAS     = 10,
   parameter int T_CCD     = 2,
   parameter int T_WTR     = 3,
   parameter int T_RFC     = 20
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    fifo_empty,
   input  logic [3:0]              fifo_cmd,
   input  logic [ADDR_BITS-1:0]    fifo_addr,
   input  logic [BA_BITS-1:0]      fifo_bank,
   output logic                    fifo_ren,
   input  logic                    phy_ready,
   output logic                    dram_valid,
   output logic [3:0]              dram_cmd,
   output logic [ADDR_BITS-1:0]    dram_addr,
   output logic [BA_BITS-1:0]      dram_bank,
   output logic [(1<<BA_BITS)-1:0] bank_open,
   output logic                    cmd_err,
   output logic                    busy
);
   localparam int NB = 1 << BA_BITS;

   localparam logic [3:0] C_NOP = 4'd0;
   localparam logic [3:0] C_ACT = 4'd1;
   localparam logic [3:0] C_RD  = 4'd2;
   localparam logic [3:0] C_WR  = 4'd3;
   localparam logic [3:0] C_PRE = 4'd4;
   localparam logic [3:0] C_REF = 4'd5;

   localparam logic [4:0] CCD_LD = 5'(T_CCD - 1);
   localparam logic [4:0] WTR_LD = 5'(T_WTR - 1);
   localparam logic [4:0] RFC_LD = 5'(T_RFC - 1);
   // With T_RFC == 1 the refresh is already over on the next cycle, so the
   // refresh state is skipped entirely.
   localparam bit RFC_LONG = (T_RFC > 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RFSH} state_t;

   state_t state_q, state_d;

   logic [NB-1:0] act_b, pre_b, open_w, rcd_ok, rp_ok, ras_ok;
   logic [4:0]    ccd_q, ccd_d, wtr_q, wtr_d, rfc_q, rfc_d;
   logic          ccd_ok, wtr_ok, rfc_ok;
   logic          is_nop, is_err, is_legal, pop, issue;

   logic                 dram_valid_q, cmd_err_q;
   logic [3:0]           dram_cmd_q;
   logic [ADDR_BITS-1:0] dram_addr_q;
   logic [BA_BITS-1:0]   dram_bank_q;

   // ---------------- per-bank state ----------------
   for (genvar g = 0; g < NB; g++) begin : g_bank
      issue_seq_bank_timer #(
         .T_RCD (T_RCD),
         .T_RP  (T_RP),
         .T_RAS (T_RAS)
      ) u_bank (
         .clk      (clk),
         .rst_n    (rst_n),
         .act_i    (act_b[g]),
         .pre_i    (pre_b[g]),
         .open_o   (open_w[g]),
         .rcd_ok_o (rcd_ok[g]),
         .rp_ok_o  (rp_ok[g]),
         .ras_ok_o (ras_ok[g])
      );
   end

   assign ccd_ok = (ccd_q == 5'd0);
   assign wtr_ok = (wtr_q == 5'd0);
   assign rfc_ok = (rfc_q == 5'd0);

   // ---------------- head decode ----------------
   // is_err: the command can never be legal from the current bank state, so it
   // is dropped. is_legal: state-legal and all timing met. Anything else stalls.
   always_comb begin
      is_nop   = 1'b0;
      is_err   = 1'b0;
      is_legal = 1'b0;
      case (fifo_cmd)
         C_NOP: is_nop = 1'b1;
         C_ACT: begin
            if (open_w[fifo_bank]) is_err = 1'b1;
            else                   is_legal = rp_ok[fifo_bank] & rfc_ok;
         end
         C_RD: begin
            if (!open_w[fifo_bank]) is_err = 1'b1;
            else is_legal = rcd_ok[fifo_bank] & ccd_ok & wtr_ok;
         end
         C_WR: begin
            if (!open_w[fifo_bank]) is_err = 1'b1;
            else is_legal = rcd_ok[fifo_bank] & ccd_ok;
         end
         C_PRE: begin
            if (!open_w[fifo_bank]) is_err = 1'b1;
            else is_legal = ras_ok[fifo_bank];
         end
         C_REF: begin
            if (|open_w) is_err = 1'b1;
            else         is_legal = (&rp_ok) & rfc_ok;
         end
         default: is_err = 1'b1;
      endcase
   end

   assign pop   = (is_nop | is_err | is_legal) & phy_ready & ~fifo_empty &
                  (state_q != S_RFSH);
   assign issue = pop & is_legal;

   always_comb begin
      act_b = '0;
      pre_b = '0;
      if (issue && fifo_cmd == C_ACT) act_b[fifo_bank] = 1'b1;
      if (issue && fifo_cmd == C_PRE) pre_b[fifo_bank] = 1'b1;
   end

   // ---------------- global timers ----------------
   always_comb begin
      ccd_d = (ccd_q == 5'd0) ? 5'd0 : ccd_q - 5'd1;
      wtr_d = (wtr_q == 5'd0) ? 5'd0 : wtr_q - 5'd1;
      rfc_d = (rfc_q == 5'd0) ? 5'd0 : rfc_q - 5'd1;
      if (issue && (fifo_cmd == C_RD || fifo_cmd == C_WR)) ccd_d = CCD_LD;
      if (issue && fifo_cmd == C_WR)  wtr_d = WTR_LD;
      if (issue && fifo_cmd == C_REF) rfc_d = RFC_LD;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ccd_q <= 5'd0;
         wtr_q <= 5'd0;
         rfc_q <= 5'd0;
      end else begin
         ccd_q <= ccd_d;
         wtr_q <= wtr_d;
         rfc_q <= rfc_d;
      end
   end

   // ---------------- PHY command register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dram_valid_q <= 1'b0;
         cmd_err_q    <= 1'b0;
         dram_cmd_q   <= '0;
         dram_addr_q  <= '0;
         dram_bank_q  <= '0;
      end else begin
         dram_valid_q <= issue;
         cmd_err_q    <= pop & is_err;
         if (issue) begin
            dram_cmd_q  <= fifo_cmd;
            dram_addr_q <= fifo_addr;
            dram_bank_q <= fifo_bank;
         end
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Leaving RFSH when rfc_q is 1 puts the FSM in WAIT/IDLE in the same cycle
   // rfc_q reaches 0, so the next command can pop exactly T_RFC after REF.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_WAIT: begin
            if (issue && fifo_cmd == C_REF && RFC_LONG) state_d = S_RFSH;
            else state_d = fifo_empty ? S_IDLE : S_WAIT;
         end
         S_RFSH: begin
            if (rfc_q <= 5'd1) state_d = fifo_empty ? S_IDLE : S_WAIT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != S_IDLE);
      fifo_ren = pop;
   end

   assign dram_valid = dram_valid_q;
   assign dram_cmd   = dram_cmd_q;
   assign dram_addr  = dram_addr_q;
   assign dram_bank  = dram_bank_q;
   assign bank_open  = open_w;
   assign cmd_err    = cmd_err_q;
endmodule

// File: tb/tb_issue_sequencer.sv
// Bench for issue_sequencer: reset-state table, directed timing sequences and
// a randomized run, all compared against a timestamp-based model of the
// DRAM rules kept here in the bench.
module tb_issue_sequencer;
   localparam int T_RCD = 4, T_RP = 4, T_RAS = 10, T_CCD = 2, T_WTR = 3, T_RFC = 20;
   localparam int NB = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fifo_empty;
   logic [3:0]  fifo_cmd;
   logic [13:0] fifo_addr;
   logic [2:0]  fifo_bank;
   logic        fifo_ren;
   logic        phy_ready;
   logic        dram_valid;
   logic [3:0]  dram_cmd;
   logic [13:0] dram_addr;
   logic [2:0]  dram_bank;
   logic [7:0]  bank_open;
   logic        cmd_err;
   logic        busy;

   always #5 clk = ~clk;

   issue_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .fifo_empty(fifo_empty), .fifo_cmd(fifo_cmd), .fifo_addr(fifo_addr),
      .fifo_bank(fifo_bank), .fifo_ren(fifo_ren), .phy_ready(phy_ready),
      .dram_valid(dram_valid), .dram_cmd(dram_cmd), .dram_addr(dram_addr),
      .dram_bank(dram_bank), .bank_open(bank_open), .cmd_err(cmd_err), .busy(busy)
   );

   typedef struct { logic [3:0] cmd; logic [13:0] addr; logic [2:0] bank; } ent_t;
   typedef struct { int cyc; logic [3:0] cmd; } log_t;
   typedef struct {
      logic [3:0] cmd; logic [2:0] bank; bit rdy;
      bit ren; bit vld; bit err; logic [7:0] opn;
   } vec_t;

   int checks = 0, errors = 0;
   int cyc;
   ent_t q[$];
   log_t lg[$];

   // model state: pop-cycle timestamps and open flags
   bit m_open[NB];
   int t_act[NB], t_pre[NB];
   int t_rw, t_wr, t_ref;
   bit prev_empty;
   bit e_valid, e_err;
   logic [3:0] e_cmd; logic [13:0] e_addr; logic [2:0] e_bank;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic bit done(input int t, input int tx);
      return (cyc - t) >= tx;
   endfunction

   // 0 stall, 1 pop+issue, 2 pop (NOP), 3 pop+error
   function automatic int classify(input ent_t e);
      int b = int'(e.bank);
      bit any_open = 0, all_rp = 1;
      for (int i = 0; i < NB; i++) begin
         any_open |= m_open[i];
         all_rp &= done(t_pre[i], T_RP);
      end
      case (e.cmd)
         4'd0: return 2;
         4'd1: return m_open[b] ? 3 : ((done(t_pre[b], T_RP) && done(t_ref, T_RFC)) ? 1 : 0);
         4'd2: return !m_open[b] ? 3 :
                ((done(t_act[b], T_RCD) && done(t_rw, T_CCD) && done(t_wr, T_WTR)) ? 1 : 0);
         4'd3: return !m_open[b] ? 3 : ((done(t_act[b], T_RCD) && done(t_rw, T_CCD)) ? 1 : 0);
         4'd4: return !m_open[b] ? 3 : (done(t_act[b], T_RAS) ? 1 : 0);
         4'd5: return any_open ? 3 : ((all_rp && done(t_ref, T_RFC)) ? 1 : 0);
         default: return 3;
      endcase
   endfunction

   function automatic logic [7:0] open_vec();
      logic [7:0] v = '0;
      for (int i = 0; i < NB; i++) v[i] = m_open[i];
      return v;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; fifo_empty = 1'b1; phy_ready = 1'b1;
      fifo_cmd = '0; fifo_addr = '0; fifo_bank = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NB; i++) begin m_open[i] = 0; t_act[i] = -1000; t_pre[i] = -1000; end
      t_rw = -1000; t_wr = -1000; t_ref = -1000;
      prev_empty = 1; e_valid = 0; e_err = 0; e_cmd = '0; e_addr = '0; e_bank = '0;
      q.delete(); lg.delete(); cyc = 0;
   endtask

   // One clock cycle: present head, check pop + busy, update model, check
   // registered outputs after the edge. Entered and left at a negedge.
   task automatic step(input bit rdy);
      int cls = 0;
      bit m_pop;
      ent_t e;
      fifo_empty = (q.size() == 0);
      if (!fifo_empty) begin
         fifo_cmd = q[0].cmd; fifo_addr = q[0].addr; fifo_bank = q[0].bank;
         cls = classify(q[0]);
      end
      phy_ready = rdy;
      #1;
      m_pop = !fifo_empty && rdy && done(t_ref, T_RFC) && (cls != 0);
      chk("fifo_ren", fifo_ren, m_pop);
      chk("busy", busy, !(prev_empty && done(t_ref, T_RFC)));
      e_valid = 0; e_err = 0;
      if (fifo_ren && q.size() > 0) begin
         e = q.pop_front();
         lg.push_back('{cyc, e.cmd});
         if (cls == 3) e_err = 1;
         if (cls == 1) begin
            e_valid = 1; e_cmd = e.cmd; e_addr = e.addr; e_bank = e.bank;
            case (e.cmd)
               4'd1: begin m_open[e.bank] = 1; t_act[e.bank] = cyc; end
               4'd4: begin m_open[e.bank] = 0; t_pre[e.bank] = cyc; end
               4'd2: t_rw = cyc;
               4'd3: begin t_rw = cyc; t_wr = cyc; end
               4'd5: t_ref = cyc;
               default: ;
            endcase
         end
      end
      prev_empty = fifo_empty;
      @(posedge clk);
      cyc++;
      #1;
      chk("dram_valid", dram_valid, e_valid);
      chk("cmd_err", cmd_err, e_err);
      chk("dram_cmd", dram_cmd, e_cmd);
      chk("dram_addr", dram_addr, e_addr);
      chk("dram_bank", dram_bank, e_bank);
      chk("bank_open", bank_open, open_vec());
      @(negedge clk);
   endtask

   task automatic push(input logic [3:0] c, input logic [2:0] b);
      q.push_back('{c, 14'($urandom), b});
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 300) begin step(1'b1); n++; end
      chk("drain_timeout", q.size(), 0);
      repeat (2) step(1'b1);
   endtask

   task automatic chk_pop(input string nm, input int idx, input int exp_cyc);
      if (lg.size() > idx) chk(nm, lg[idx].cyc, exp_cyc);
      else chk({nm, "_missing"}, lg.size(), idx + 1);
   endtask

   vec_t vt[9];

   initial begin
      // single-cycle legality from the reset state
      vt[0] = '{4'd0,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[1] = '{4'd1,  3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h04};
      vt[2] = '{4'd2,  3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
      vt[3] = '{4'd3,  3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
      vt[4] = '{4'd4,  3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
      vt[5] = '{4'd5,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
      vt[6] = '{4'd7,  3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
      vt[7] = '{4'd1,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vt[8] = '{4'd15, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};

      for (int i = 0; i < 9; i++) begin
         do_reset();
         fifo_empty = 1'b0; fifo_cmd = vt[i].cmd; fifo_bank = vt[i].bank;
         fifo_addr = 14'h1234; phy_ready = vt[i].rdy;
         #1;
         chk("tbl_ren", fifo_ren, vt[i].ren);
         @(posedge clk); #1;
         chk("tbl_valid", dram_valid, vt[i].vld);
         chk("tbl_err", cmd_err, vt[i].err);
         chk("tbl_open", bank_open, vt[i].opn);
         if (vt[i].vld) chk("tbl_cmd", dram_cmd, vt[i].cmd);
         @(negedge clk);
         fifo_empty = 1'b1;
      end

      // empty after reset, then ACT/READ bank2: READ pops T_RCD after ACT
      do_reset();
      repeat (10) step(1'b1);
      push(4'd1, 3'd2); push(4'd2, 3'd2);
      drain();
      chk_pop("act_b2_cyc", 0, 10);
      chk_pop("rd_b2_cyc", 1, 14);

      // ACT / PRE / ACT bank0 with T_RAS then T_RP, then REF waits T_RP after PRE
      do_reset();
      push(4'd1, 3'd0); push(4'd4, 3'd0); push(4'd1, 3'd0);
      push(4'd4, 3'd0); push(4'd5, 3'd0); push(4'd1, 3'd3);
      drain();
      chk_pop("pre_ras", 1, 10);
      chk_pop("act_rp", 2, 14);
      chk_pop("pre2_ras", 3, 24);
      chk_pop("ref_rp", 4, 28);
      chk_pop("act_rfc", 5, 48);

      // ACT, WRITE, READ, READ bank1: T_RCD, T_WTR, T_CCD
      do_reset();
      push(4'd1, 3'd1); push(4'd3, 3'd1); push(4'd2, 3'd1); push(4'd2, 3'd1);
      drain();
      chk_pop("wr_rcd", 1, 4);
      chk_pop("rd_wtr", 2, 7);
      chk_pop("rd_ccd", 3, 9);

      // illegal heads drop immediately without stalling
      do_reset();
      push(4'd2, 3'd3); push(4'd1, 3'd0); push(4'd5, 3'd0); push(4'd1, 3'd0);
      drain();
      chk_pop("rd_closed", 0, 0);
      chk_pop("ref_open_err", 2, 2);
      chk_pop("act_open_err", 3, 3);

      // phy_ready low holds a legal head
      do_reset();
      push(4'd1, 3'd4);
      repeat (5) step(1'b0);
      drain();
      chk_pop("phy_hold", 0, 5);

      // randomized traffic against the model
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         if (q.size() < 6 && $urandom_range(0, 9) < 6) begin
            int r = $urandom_range(0, 99);
            logic [3:0] c;
            if (r < 5) c = 4'd0;
            else if (r < 32) c = 4'd1;
            else if (r < 50) c = 4'd2;
            else if (r < 64) c = 4'd3;
            else if (r < 88) c = 4'd4;
            else if (r < 94) c = 4'd5;
            else c = 4'($urandom_range(6, 15));
            push(c, 3'($urandom_range(0, 3)));
         end
         step($urandom_range(0, 3) != 0);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/issue_sequencer.md
Name: issue_sequencer

Overview:
Sits between the issue FIFO (head entry: {command, addr, bank}) and the DDR PHY command port. Examines the FIFO head each cycle and checks per-bank and global DRAM timing and bank state. Pops the head only when it is legal to issue, then drives the registered command onto the PHY interface. This is the single reader of the issue FIFO; the scheduler front-end only writes it.

Parameters:
BA_BITS, 3, bank address width (banks = 2**BA_BITS)
ADDR_BITS, 14, row+column address width carried through
T_RCD, 4, ACT to READ/WRITE same bank, cycles
T_RP, 4, PRE to ACT same bank, cycles
T_RAS, 10, ACT to PRE same bank, cycles
T_CCD, 2, READ/WRITE to READ/WRITE any bank, cycles
T_WTR, 3, WRITE to READ any bank, cycles
T_RFC, 20, REF to any command, cycles (all T_* in 1..31)

Ports:
clk  in  1  clock
rst_n  in  1  reset: synchronous, active-low
fifo_empty  in  1  issue FIFO empty
fifo_cmd  in  4  head command: 0 NOP, 1 ACT, 2 READ, 3 WRITE, 4 PRE, 5 REF, others undefined
fifo_addr  in  ADDR_BITS  head address
fifo_bank  in  BA_BITS  head bank
fifo_ren  out  1  pop strobe to FIFO (combinational)
phy_ready  in  1  PHY can accept a command this cycle
dram_valid  out  1  registered command valid
dram_cmd  out  4  registered command code
dram_addr  out  ADDR_BITS  registered address
dram_bank  out  BA_BITS  registered bank
bank_open  out  2**BA_BITS  per-bank open flags
cmd_err  out  1  one-cycle pulse: illegal head dropped
busy  out  1  FSM not IDLE

Behaviour:
- Reset: all outputs 0, all banks closed, all timing counters 0, FSM = IDLE. Reset mid-operation discards pending timing and bank state. FIFO contents are not touched.
- Timing counters: 5-bit down-counters, saturating at 0, decremented every cycle.
  - Per bank: rcd, rp, ras.
  - Global: ccd, wtr, rfc.
  - Rule: for each T_X, a constrained command may pop no earlier than T_X cycles after the pop cycle of the constraining command.
- Legality of head (fifo_empty=0):
  - ACT: bank closed, rp[b] done, rfc done.
  - READ: bank open, rcd[b], ccd, wtr done.
  - WRITE: bank open, rcd[b], ccd done.
  - PRE: bank open, ras[b] done.
  - REF: all banks closed, all rp done, rfc done.
  - NOP: always legal; popped, not issued.
- fifo_ren = legal & phy_ready & ~fifo_empty & (state != RFSH). A legal head is popped in the same cycle the check passes.
- Issue: on a pop of a non-NOP command, dram_valid/cmd/addr/bank are registered at that clock edge and valid for exactly one cycle (latency 1). Otherwise dram_valid=0 and the data outputs hold their last values.
- State updates at the pop edge:
  - ACT: opens bank, loads rcd[b], ras[b].
  - PRE: closes bank, loads rp[b].
  - READ: loads ccd.
  - WRITE: loads ccd, wtr.
  - REF: loads rfc.
- Illegal by state: READ/WRITE/PRE to a closed bank, ACT to an open bank, REF with any bank open, undefined code.
  - Head popped (subject to phy_ready), not issued, cmd_err=1 for one cycle, bank state unchanged.
  - Timing-only violations are never errors; they stall.
- FSM:
  - IDLE: fifo_empty=1. Goes to WAIT on non-empty.
  - WAIT: head present but not legal or phy_ready=0. Pops on legal.
  - RFSH: entered on REF pop; no pops until rfc reaches 0; then to WAIT if non-empty, else IDLE.
  - A pop that empties the FIFO returns to IDLE next cycle.
- phy_ready=0: no pop, all counters keep decrementing, no state change.
- Back-to-back: one pop per cycle maximum.

Test Plan:
- Reset then fifo_empty=1 for 10 cycles -> fifo_ren=0, dram_valid=0, bank_open=0, busy=0 throughout.
- ACT bank2 popped cycle 10, READ bank2 at head -> READ pops cycle 14 (T_RCD=4), dram_valid cycle 15 with dram_cmd=2, dram_bank=2.
- ACT bank0 cycle 5, PRE bank0 queued -> pops cycle 15 (T_RAS=10); following ACT bank0 pops cycle 19 (T_RP=4); bank_open[0] 1->0->1.
- WRITE bank1 cycle 20 then READ bank1 -> READ pops cycle 23 (T_WTR=3, not T_CCD=2).
- READ to closed bank3 -> popped, cmd_err=1 one cycle, dram_valid=0, bank_open unchanged.
- REF with all banks closed popped cycle 30 -> busy=1 in RFSH, next ACT pops cycle 50. Same REF with bank0 open -> cmd_err. phy_ready=0 during a legal head -> no pop until phy_ready returns.
